// File: rtl/trace_stream_arbiter.sv
// Round-robin arbiter sharing one AXI-Stream trace sink among NUM_SRC sources.
// A grant is held until the packet ends (source tlast or a forced tlast after MAX_BEATS beats).
module trace_stream_arbiter #(
    parameter int NUM_SRC    = 2,
    parameter int DATA_WIDTH = 96,
    parameter int MAX_BEATS  = 256,
    localparam int IDW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_SRC-1:0]              src_enable,
    input  logic [NUM_SRC-1:0]              s_axis_tvalid,
    output logic [NUM_SRC-1:0]              s_axis_tready,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [NUM_SRC-1:0]              s_axis_tlast,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic [DATA_WIDTH-1:0]           m_axis_tdata,
    output logic                            m_axis_tlast,
    output logic [IDW-1:0]                  m_axis_tid,
    output logic                            busy
);

    localparam int CW = (MAX_BEATS > 0) ? $clog2(MAX_BEATS + 1) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'((MAX_BEATS > 0) ? MAX_BEATS - 1 : 0);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t             state, next_state;
    logic [IDW-1:0]     grant, last_grant, pick;
    logic [CW-1:0]      beat_cnt;
    logic [NUM_SRC-1:0] cand;
    logic               found, locked, beat, forced, src_tlast, eop;

    assign cand   = s_axis_tvalid & src_enable;
    assign locked = (state == LOCKED);
    assign busy   = locked;

    // Walk distances from farthest to nearest so the source right after last_grant wins.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (cand[i] && (((int'(last_grant) + k) % NUM_SRC) == i)) begin
                    found = 1'b1;
                    pick  = IDW'(i);
                end
            end
        end
    end

    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        src_tlast     = 1'b0;
        s_axis_tready = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (locked && (grant == IDW'(i))) begin
                m_axis_tvalid    = s_axis_tvalid[i];
                m_axis_tdata     = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                src_tlast        = s_axis_tlast[i];
                s_axis_tready[i] = m_axis_tready;
            end
        end
    end

    assign forced       = (MAX_BEATS != 0) && (beat_cnt == LAST_CNT);
    assign m_axis_tlast = locked & (src_tlast | forced);
    assign m_axis_tid   = locked ? grant : '0;
    assign beat         = m_axis_tvalid & m_axis_tready;
    assign eop          = beat & m_axis_tlast;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (found) next_state = LOCKED;
            LOCKED:  if (eop)   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= IDW'(NUM_SRC - 1);
            beat_cnt   <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && found) grant <= pick;
            if (eop) begin
                last_grant <= grant;
                beat_cnt   <= '0;
            end else if (beat) begin
                beat_cnt <= beat_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_trace_stream_arbiter.sv
// Directed bench for trace_stream_arbiter: two sources, forced tlast every 4 beats.
module tb_trace_stream_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  en, v, lst, s_tready;
    logic [95:0] d0, d1, m_tdata;
    logic        m_tvalid, mready, m_tlast, busy;
    logic [0:0]  m_tid;

    int checks = 0;
    int errors = 0;
    int n, s, bc0, bc1;
    logic exp_busy, el;
    logic [4:0] rdy;

    always #5 clk = ~clk;

    trace_stream_arbiter #(.NUM_SRC(2), .DATA_WIDTH(96), .MAX_BEATS(4)) dut (
        .clk(clk), .rst(rst), .src_enable(en),
        .s_axis_tvalid(v), .s_axis_tready(s_tready), .s_axis_tdata({d1, d0}), .s_axis_tlast(lst),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(mready), .m_axis_tdata(m_tdata),
        .m_axis_tlast(m_tlast), .m_axis_tid(m_tid), .busy(busy)
    );

    function automatic logic [95:0] dat(input int src, input int beat);
        return {16'hBEEF, 16'(src), 32'h1234_5678, 32'(beat)};
    endfunction

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1; v = '0; lst = '0; en = 2'b11; mready = 1'b1;
        d0 = '0; d1 = '0;
        tick();
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_tready", s_tready, 0);
        chk("rst_tlast", m_tlast, 0);
        chk("rst_tid", m_tid, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
    endtask

    initial begin
        // Single 3-beat packet from src0
        reset_dut();
        v = 2'b01; d0 = dat(0, 1); #1;
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_tvalid", m_tvalid, 0);
        chk("t1_idle_tready", s_tready, 0);
        tick();
        for (int b = 1; b <= 3; b++) begin
            d0 = dat(0, b); lst[0] = (b == 3); #1;
            chk("t1_busy", busy, 1);
            chk("t1_tvalid", m_tvalid, 1);
            chk("t1_tid", m_tid, 0);
            chk("t1_tdata", m_tdata, dat(0, b));
            chk("t1_tready", s_tready, 2'b01);
            chk("t1_tlast", m_tlast, (b == 3));
            tick();
        end
        v = '0; lst = '0; #1;
        chk("t1_busy_fall", busy, 0);

        // Both sources streaming 2-beat packets alternate
        reset_dut();
        bc0 = 0; bc1 = 0; v = 2'b11;
        for (int p = 0; p < 4; p++) begin
            s = p % 2;
            d0 = dat(0, bc0); lst[0] = (bc0 % 2 == 1);
            d1 = dat(1, bc1); lst[1] = (bc1 % 2 == 1); #1;
            chk("t2_idle_tvalid", m_tvalid, 0);
            chk("t2_idle_busy", busy, 0);
            tick();
            for (int q = 0; q < 2; q++) begin
                d0 = dat(0, bc0); lst[0] = (bc0 % 2 == 1);
                d1 = dat(1, bc1); lst[1] = (bc1 % 2 == 1); #1;
                chk("t2_tid", m_tid, s);
                chk("t2_tdata", m_tdata, dat(s, (s == 1) ? bc1 : bc0));
                chk("t2_tlast", m_tlast, (q == 1));
                chk("t2_tready", s_tready, 1 << s);
                tick();
                if (s == 0) bc0++; else bc1++;
            end
        end

        // src1 streams 10 beats with only the final beat marked; forced tlast on 4 and 8
        reset_dut();
        v = 2'b10; n = 1; exp_busy = 1'b0;
        for (int c = 0; c < 20 && n <= 10; c++) begin
            d1 = dat(1, n); lst[1] = (n == 10); #1;
            chk("t3_busy", busy, exp_busy);
            if (exp_busy) begin
                el = (n % 4 == 0) || (n == 10);
                chk("t3_tid", m_tid, 1);
                chk("t3_tdata", m_tdata, dat(1, n));
                chk("t3_tlast", m_tlast, el);
                n++;
                if (el) exp_busy = 1'b0;
            end else begin
                exp_busy = 1'b1;
            end
            tick();
        end
        chk("t3_beats_done", n, 11);

        // Backpressure 1,0,0,1,1 during a 3-beat src0 packet, src1 waiting
        reset_dut();
        v = 2'b11; d0 = dat(0, 1); d1 = dat(1, 7); n = 1; rdy = 5'b11001; #1;
        chk("t4_idle_busy", busy, 0);
        tick();
        for (int c = 0; c < 5; c++) begin
            mready = rdy[c]; d0 = dat(0, n); lst[0] = (n == 3); #1;
            chk("t4_tvalid", m_tvalid, 1);
            chk("t4_tid", m_tid, 0);
            chk("t4_tdata", m_tdata, dat(0, n));
            chk("t4_tready1", s_tready[1], 0);
            chk("t4_tready0", s_tready[0], mready);
            if (mready) begin
                chk("t4_tlast", m_tlast, (n == 3));
                n++;
            end
            tick();
        end
        chk("t4_beats_done", n, 4);
        v[0] = 1'b0; lst = '0; #1;
        chk("t4_end_busy", busy, 0);

        // Disabled source never wins; disabling the granted source mid-packet is harmless
        reset_dut();
        en = 2'b01; v = 2'b10; d1 = dat(1, 3);
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("t5_no_grant_busy", busy, 0);
            chk("t5_no_grant_tready", s_tready, 0);
            tick();
        end
        v = 2'b11; n = 1; d0 = dat(0, 1); #1;
        chk("t5_idle_busy", busy, 0);
        tick();
        for (int b = 1; b <= 3; b++) begin
            d0 = dat(0, b); lst[0] = (b == 3); #1;
            chk("t5_busy", busy, 1);
            chk("t5_tid", m_tid, 0);
            chk("t5_tdata", m_tdata, dat(0, b));
            chk("t5_tlast", m_tlast, (b == 3));
            tick();
            if (b == 1) en = 2'b00;
        end
        v[0] = 1'b0; lst = '0;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("t5_after_busy", busy, 0);
            chk("t5_after_tvalid", m_tvalid, 0);
            tick();
        end

        // Reset mid-packet abandons it and restores src0 priority
        reset_dut();
        v = 2'b01; lst = 2'b01; d0 = dat(0, 9); #1;
        tick();
        #1;
        chk("t6_pre_tid", m_tid, 0);
        chk("t6_pre_tlast", m_tlast, 1);
        tick();
        v = 2'b11; lst = 2'b00; d0 = dat(0, 1); d1 = dat(1, 1); #1;
        chk("t6_idle_busy", busy, 0);
        tick();
        #1;
        chk("t6_beat1_tid", m_tid, 1);
        tick();
        d1 = dat(1, 2); #1;
        chk("t6_beat2_busy", busy, 1);
        rst = 1'b1; #1;
        chk("t6_rst_tvalid", m_tvalid, 0);
        chk("t6_rst_tready", s_tready, 0);
        chk("t6_rst_tlast", m_tlast, 0);
        chk("t6_rst_tid", m_tid, 0);
        chk("t6_rst_busy", busy, 0);
        tick();
        rst = 1'b0; #1;
        chk("t6_rel_busy", busy, 0);
        tick();
        #1;
        chk("t6_regrant_busy", busy, 1);
        chk("t6_regrant_tid", m_tid, 0);
        chk("t6_regrant_tdata", m_tdata, dat(0, 1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
